// File: rtl/pet_pkg.sv
// Shared definitions for the pet need engine.
//   need_state_e : per-channel FSM state codes (also the state_out encoding)
//   mood_e       : summary mood codes driven on the mood output
//   slot_lsb()   : LSB position of a channel's field in a packed output bus
package pet_pkg;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_LOW  = 2'd1,
    ST_CRIT = 2'd2,
    ST_SERV = 2'd3
  } need_state_e;

  typedef enum logic [1:0] {
    MOOD_HAPPY = 2'd0,
    MOOD_NEEDY = 2'd1,
    MOOD_CRIT  = 2'd2,
    MOOD_SERV  = 2'd3
  } mood_e;

  // Channel 0 occupies the least significant field.
  function automatic int unsigned slot_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/need_channel.sv
// One need channel: level counter, decay prescaler and 4-state FSM.
//   clk, reset     : clock, asynchronous active-low reset
//   tick           : one-cycle time strobe
//   btn            : this channel's service button (level)
//   grant          : arbiter grant, only ever set for a LOW/CRITICAL channel
//   test_mode      : freezes decay/refill/button handling
//   test_adv       : single-cycle strobe, advance state by one in test mode
//   level, state   : registered level and state
//   state_next     : next-state value, used by the top for registered summaries
module need_channel
  import pet_pkg::*;
#(
  parameter int unsigned LEVEL_W     = 3,
  parameter int unsigned LEVEL_MAX   = 7,
  parameter int unsigned LOW_TH      = 4,
  parameter int unsigned CRIT_TH     = 1,
  parameter int unsigned DECAY_TICKS = 10,
  parameter int unsigned REFILL_STEP = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               btn,
  input  logic               grant,
  input  logic               test_mode,
  input  logic               test_adv,
  output logic [LEVEL_W-1:0] level,
  output need_state_e        state,
  output need_state_e        state_next
);

  localparam int unsigned CNT_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  need_state_e        state_q, state_d;
  logic [LEVEL_W:0]   refill_sum;

  assign refill_sum = {1'b0, level_q} + (LEVEL_W+1)'(REFILL_STEP);

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (test_mode) begin
      if (test_adv) state_d = need_state_e'(state_q + 2'd1);
    end else begin
      if (tick) begin
        if (state_q == ST_SERV) begin
          if (refill_sum >= (LEVEL_W+1)'(LEVEL_MAX)) level_d = LEVEL_W'(LEVEL_MAX);
          else                                       level_d = refill_sum[LEVEL_W-1:0];
        end else if (cnt_q == CNT_W'(DECAY_TICKS - 1)) begin
          cnt_d = '0;
          if (level_q != '0) level_d = level_q - LEVEL_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Transitions look at the pre-update level, not level_d.
      unique case (state_q)
        ST_OK: begin
          if (level_q <= LEVEL_W'(LOW_TH)) state_d = ST_LOW;
        end
        ST_LOW: begin
          if (grant)                             state_d = ST_SERV;
          else if (level_q <= LEVEL_W'(CRIT_TH)) state_d = ST_CRIT;
          else if (level_q >  LEVEL_W'(LOW_TH))  state_d = ST_OK;
        end
        ST_CRIT: begin
          if (grant) state_d = ST_SERV;
        end
        ST_SERV: begin
          if (!btn) begin
            if (level_q == LEVEL_W'(LEVEL_MAX))   state_d = ST_OK;
            else if (level_q > LEVEL_W'(CRIT_TH)) state_d = ST_LOW;
            else                                  state_d = ST_CRIT;
          end
        end
        default: state_d = ST_OK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= LEVEL_W'(LEVEL_MAX);
      cnt_q   <= '0;
      state_q <= ST_OK;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign level      = level_q;
  assign state      = state_q;
  assign state_next = state_d;

endmodule

// File: rtl/pet_need_engine.sv
// Multi-channel pet need engine.
//   clk, reset   : clock, asynchronous active-low reset
//   tick         : one-cycle time strobe
//   btn          : per-channel service buttons (synchronised, level)
//   test_mode    : manual test mode
//   test_step    : rising edge advances channel test_sel one state
//   test_sel     : channel selected for test stepping
//   level_out    : packed levels, channel 0 in LSBs
//   state_out    : packed 2-bit state codes
//   btn_enable   : channels currently allowed to accept service
//   mood         : 0 happy, 1 needy, 2 critical, 3 servicing
//   any_critical : some channel is CRITICAL
module pet_need_engine
  import pet_pkg::*;
#(
  parameter int unsigned N_NEEDS     = 4,
  parameter int unsigned LEVEL_W     = 3,
  parameter int unsigned LEVEL_MAX   = 7,
  parameter int unsigned LOW_TH      = 4,
  parameter int unsigned CRIT_TH     = 1,
  parameter int unsigned DECAY_TICKS = 10,
  parameter int unsigned REFILL_STEP = 1,
  parameter int unsigned SEL_W       = (N_NEEDS > 1) ? $clog2(N_NEEDS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [N_NEEDS-1:0]           btn,
  input  logic                         test_mode,
  input  logic                         test_step,
  input  logic [SEL_W-1:0]             test_sel,
  output logic [N_NEEDS*LEVEL_W-1:0]   level_out,
  output logic [N_NEEDS*2-1:0]         state_out,
  output logic [N_NEEDS-1:0]           btn_enable,
  output logic [1:0]                   mood,
  output logic                         any_critical
);

  logic [LEVEL_W-1:0] lvl    [N_NEEDS];
  need_state_e        st_q   [N_NEEDS];
  need_state_e        st_nxt [N_NEEDS];
  logic [N_NEEDS-1:0] grant;
  logic [N_NEEDS-1:0] test_adv;
  logic               any_serv;
  logic               found;
  logic               test_edge;

  logic               test_step_prev_q, test_step_prev_d;
  logic [N_NEEDS-1:0] btn_enable_q, btn_enable_d;
  mood_e              mood_q, mood_d;
  logic               any_critical_q, any_critical_d;

  logic               nxt_serv, nxt_crit, nxt_low;
  logic [N_NEEDS-1:0] nxt_serv_mask;

  assign test_edge        = test_step && !test_step_prev_q;
  assign test_step_prev_d = test_step;

  // Arbiter: grants only while nobody is servicing; lowest index wins.
  always_comb begin
    any_serv = 1'b0;
    found    = 1'b0;
    grant    = '0;
    test_adv = '0;
    for (int unsigned i = 0; i < N_NEEDS; i++) begin
      if (st_q[i] == ST_SERV) any_serv = 1'b1;
    end
    for (int unsigned i = 0; i < N_NEEDS; i++) begin
      if (!test_mode && !any_serv && !found && btn[i] &&
          (st_q[i] == ST_LOW || st_q[i] == ST_CRIT)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
      // An out-of-range test_sel matches no channel, so the step is dropped.
      test_adv[i] = test_mode && test_edge && (test_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < N_NEEDS; g++) begin : g_ch
    need_channel #(
      .LEVEL_W     (LEVEL_W),
      .LEVEL_MAX   (LEVEL_MAX),
      .LOW_TH      (LOW_TH),
      .CRIT_TH     (CRIT_TH),
      .DECAY_TICKS (DECAY_TICKS),
      .REFILL_STEP (REFILL_STEP)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .btn        (btn[g]),
      .grant      (grant[g]),
      .test_mode  (test_mode),
      .test_adv   (test_adv[g]),
      .level      (lvl[g]),
      .state      (st_q[g]),
      .state_next (st_nxt[g])
    );
    assign level_out[slot_lsb(g, LEVEL_W) +: LEVEL_W] = lvl[g];
    assign state_out[slot_lsb(g, 2) +: 2]             = st_q[g];
  end

  // Summaries are built from next-state values so that, once registered,
  // they line up with state_out on the same cycle.
  always_comb begin
    nxt_serv      = 1'b0;
    nxt_crit      = 1'b0;
    nxt_low       = 1'b0;
    nxt_serv_mask = '0;
    for (int unsigned i = 0; i < N_NEEDS; i++) begin
      if (st_nxt[i] == ST_SERV) begin
        nxt_serv         = 1'b1;
        nxt_serv_mask[i] = 1'b1;
      end
      if (st_nxt[i] == ST_CRIT) nxt_crit = 1'b1;
      if (st_nxt[i] == ST_LOW)  nxt_low  = 1'b1;
    end
    btn_enable_d   = nxt_serv ? nxt_serv_mask : '1;
    any_critical_d = nxt_crit;
    if (nxt_serv)      mood_d = MOOD_SERV;
    else if (nxt_crit) mood_d = MOOD_CRIT;
    else if (nxt_low)  mood_d = MOOD_NEEDY;
    else               mood_d = MOOD_HAPPY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      test_step_prev_q <= 1'b0;
      btn_enable_q     <= '1;
      mood_q           <= MOOD_HAPPY;
      any_critical_q   <= 1'b0;
    end else begin
      test_step_prev_q <= test_step_prev_d;
      btn_enable_q     <= btn_enable_d;
      mood_q           <= mood_d;
      any_critical_q   <= any_critical_d;
    end
  end

  assign btn_enable   = btn_enable_q;
  assign mood         = mood_q;
  assign any_critical = any_critical_q;

endmodule

// File: tb/tb_pet_need_engine.sv
module tb_pet_need_engine;

  localparam int N    = 4;
  localparam int LMAX = 7;
  localparam int LOWT = 4;
  localparam int CRTT = 1;
  localparam int DEC  = 10;
  localparam int REF  = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [N-1:0]  btn;
  logic          test_mode;
  logic          test_step;
  logic [1:0]    test_sel;
  logic [N*3-1:0] level_out;
  logic [N*2-1:0] state_out;
  logic [N-1:0]  btn_enable;
  logic [1:0]    mood;
  logic          any_critical;

  pet_need_engine #(
    .N_NEEDS     (N),
    .LEVEL_W     (3),
    .LEVEL_MAX   (LMAX),
    .LOW_TH      (LOWT),
    .CRIT_TH     (CRTT),
    .DECAY_TICKS (DEC),
    .REFILL_STEP (REF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .btn          (btn),
    .test_mode    (test_mode),
    .test_step    (test_step),
    .test_sel     (test_sel),
    .level_out    (level_out),
    .state_out    (state_out),
    .btn_enable   (btn_enable),
    .mood         (mood),
    .any_critical (any_critical)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*3-1:0] lv;
    logic [N*2-1:0] st;
    logic [N-1:0]   be;
    logic [1:0]     md;
    logic           ac;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-channel ints, states 0 OK,1 LOW,2 CRIT,3 SERV.
  int m_lvl[N];
  int m_st[N];
  int m_cnt[N];
  bit m_prev;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_lvl[i] = LMAX; m_st[i] = 0; m_cnt[i] = 0;
    end
    m_prev = 0;
  endfunction

  function automatic exp_t model_step(input bit tk, input bit [N-1:0] b, input bit tm,
                                      input bit ts, input int sel);
    int nl[N]; int ns[N]; int nc[N];
    bit busy = 0;
    int win = -1;
    exp_t e;
    for (int i = 0; i < N; i++) if (m_st[i] == 3) busy = 1;
    if (!tm && !busy)
      for (int i = 0; i < N; i++)
        if (win < 0 && b[i] && (m_st[i] == 1 || m_st[i] == 2)) win = i;
    for (int i = 0; i < N; i++) begin
      nl[i] = m_lvl[i]; ns[i] = m_st[i]; nc[i] = m_cnt[i];
      if (tm) begin
        if (ts && !m_prev && sel == i) ns[i] = (m_st[i] + 1) % 4;
      end else begin
        if (tk) begin
          if (m_st[i] == 3) nl[i] = (m_lvl[i] + REF > LMAX) ? LMAX : m_lvl[i] + REF;
          else if (m_cnt[i] == DEC - 1) begin
            nc[i] = 0;
            nl[i] = (m_lvl[i] > 0) ? m_lvl[i] - 1 : 0;
          end else nc[i] = m_cnt[i] + 1;
        end
        case (m_st[i])
          0: if (m_lvl[i] <= LOWT) ns[i] = 1;
          1: if (win == i) ns[i] = 3;
             else if (m_lvl[i] <= CRTT) ns[i] = 2;
             else if (m_lvl[i] > LOWT) ns[i] = 0;
          2: if (win == i) ns[i] = 3;
          default: if (!b[i]) ns[i] = (m_lvl[i] == LMAX) ? 0 : (m_lvl[i] > CRTT) ? 1 : 2;
        endcase
      end
    end
    m_prev = ts;
    e.lv = '0; e.st = '0; e.be = '0; e.md = 0; e.ac = 0;
    busy = 0;
    for (int i = 0; i < N; i++) begin
      m_lvl[i] = nl[i]; m_st[i] = ns[i]; m_cnt[i] = nc[i];
      e.lv[i*3 +: 3] = 3'(nl[i]);
      e.st[i*2 +: 2] = 2'(ns[i]);
      if (ns[i] == 3) begin busy = 1; e.be[i] = 1'b1; end
      if (ns[i] == 2) e.ac = 1'b1;
    end
    if (!busy) e.be = '1;
    if (busy) e.md = 3;
    else if (e.ac) e.md = 2;
    else begin
      for (int i = 0; i < N; i++) if (ns[i] == 1) e.md = 1;
    end
    return e;
  endfunction

  task automatic drive(input bit tk, input bit [N-1:0] b, input bit tm,
                       input bit ts, input int sel);
    @(negedge clk);
    reset = 1'b1; tick = tk; btn = b; test_mode = tm; test_step = ts; test_sel = 2'(sel);
    exp_q.push_back(model_step(tk, b, tm, ts, sel));
  endtask

  task automatic check_reset_vals();
    chk("rst_level", int'(level_out), 12'hFFF);
    chk("rst_state", int'(state_out), 0);
    chk("rst_btn_en", int'(btn_enable), 4'hF);
    chk("rst_mood", int'(mood), 0);
    chk("rst_anycrit", int'(any_critical), 0);
  endtask

  // Monitor: every cycle with an outstanding expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("level_out", int'(level_out), int'(e.lv));
        chk("state_out", int'(state_out), int'(e.st));
        chk("btn_enable", int'(btn_enable), int'(e.be));
        chk("mood", int'(mood), int'(e.md));
        chk("any_critical", int'(any_critical), int'(e.ac));
      end
    end
  end

  initial begin
    bit [N-1:0] rb;
    bit rtm;
    int r;
    reset = 1'b0; tick = 0; btn = '0; test_mode = 0; test_step = 0; test_sel = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_vals();

    // Decay to LOW then CRITICAL, then service channel 1 and release.
    for (int i = 0; i < 60; i++) drive(1, '0, 0, 0, 0);
    drive(0, '0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(1, 4'b0010, 0, 0, 0);
    drive(0, '0, 0, 0, 0);
    drive(0, 4'b0110, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 4'b0110, 0, 0, 0);
    drive(0, '0, 0, 0, 0);

    // Test mode: three edges on channel 2, ticks frozen, then held step.
    for (int k = 0; k < 3; k++) begin
      drive(0, '0, 1, 1, 2);
      drive(1, '0, 1, 0, 2);
    end
    for (int i = 0; i < 20; i++) drive(1, 4'b1111, 1, 0, 2);
    for (int i = 0; i < 5; i++) drive(1, '0, 1, 1, 2);
    drive(0, '0, 0, 0, 0);

    // Randomised operation.
    rb = '0; rtm = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 5);
        if (r == 0) rb = '0;
        else if (r == 5) rb = 4'($urandom_range(0, 15));
        else rb = 4'(1 << (r - 1));
      end
      if ($urandom_range(0, 99) == 0) rtm = ~rtm;
      drive(1'($urandom_range(0, 1)), rb, rtm, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Asynchronous reset while channel 0 services at level 5.
    @(negedge clk); reset = 1'b0; model_reset();
    @(negedge clk);
    for (int i = 0; i < 30; i++) drive(1, '0, 0, 0, 0);
    drive(0, '0, 0, 0, 0);
    drive(0, 4'b0001, 0, 0, 0);
    drive(1, 4'b0001, 0, 0, 0);
    drive(0, 4'b0001, 0, 0, 0);
    @(posedge clk); #1;
    chk("pre_rst_ch0_state", int'(state_out[1:0]), 3);
    chk("pre_rst_ch0_level", int'(level_out[2:0]), 5);
    @(negedge clk);
    reset = 1'b0;
    #1 check_reset_vals();
    model_reset();
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pet_need_engine.md
Name: pet_need_engine

Overview:
- Multi-channel successor to the single-need pet state machine.
- Tracks N_NEEDS independent need levels (e.g. food, medicine, sleep, play). Each level decays on a time tick and is refilled while its service button is held.
- Each channel runs its own 4-state FSM. Service access is one channel at a time.
- Includes a clean, synchronous edge-detected test-step mode.
- Sits between the input debouncers/tick generator and the display/7-segment driver.

Parameters:
- N_NEEDS, 4, number of need channels.
- LEVEL_W, 3, width of each level counter.
- LEVEL_MAX, 7, full level; reset value; saturation ceiling.
- LOW_TH, 4, level at or below which a channel is LOW.
- CRIT_TH, 1, level at or below which a channel is CRITICAL.
- DECAY_TICKS, 10, tick pulses per 1-unit decay.
- REFILL_STEP, 1, level gain per tick while servicing.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- tick  in  1  one-cycle time strobe
- btn  in  N_NEEDS  synchronised service buttons, level-sensitive
- test_mode  in  1  1 = manual test mode
- test_step  in  1  test advance input, rising-edge detected
- test_sel  in  $clog2(N_NEEDS)  channel advanced by test_step
- level_out  out  N_NEEDS*LEVEL_W  packed levels, channel 0 in LSBs
- state_out  out  N_NEEDS*2  packed state codes
- btn_enable  out  N_NEEDS  1 = channel may accept service
- mood  out  2  0 happy, 1 needy, 2 critical, 3 servicing
- any_critical  out  1  OR of CRITICAL over all channels

Behaviour:
- Reset (asynchronous, active-low) sets:
  - all levels = LEVEL_MAX, all states = OK (code 0), decay counters = 0;
  - btn_enable = all 1s, mood = 0, any_critical = 0, test_step_prev = 0.
- All outputs are registered. A cause sampled at edge t is visible after edge t+1.
- State codes: OK = 0, LOW = 1, CRITICAL = 2, SERVICING = 3.
- Decay:
  - Applies when test_mode = 0 and the state is not SERVICING.
  - Each tick increments the decay counter.
  - On tick with counter = DECAY_TICKS-1: counter wraps to 0 and level decrements, saturating at 0.
  - In SERVICING the decay counter holds its value.
- Refill: in SERVICING, each tick adds REFILL_STEP to the level, saturating at LEVEL_MAX.
- FSM transitions are evaluated on the registered (pre-update) level.
  - OK: level <= LOW_TH -> LOW. A button press has no effect.
  - LOW, priority order:
    - granted btn -> SERVICING;
    - else level <= CRIT_TH -> CRITICAL;
    - else level > LOW_TH -> OK.
  - CRITICAL: granted btn -> SERVICING; otherwise stay.
  - SERVICING:
    - stays while btn is held, even when the level is saturated;
    - on release: level = LEVEL_MAX -> OK; level > CRIT_TH -> LOW; else CRITICAL.
- Service arbitration:
  - A btn is granted only if no channel is in SERVICING.
  - Among simultaneous requests from LOW/CRITICAL channels, the lowest index wins.
  - While any channel is SERVICING, btn_enable = 0 for all other channels and their btn is ignored. The servicing channel keeps btn_enable = 1.
- mood priority: any SERVICING -> 3; else any CRITICAL -> 2; else any LOW -> 1; else 0.
- Test mode:
  - While test_mode = 1: decay, refill and btn are frozen/ignored.
  - test_step_prev is registered every cycle regardless of mode.
  - A rising edge (test_step = 1 and prev = 0) advances channel test_sel one state: OK -> LOW -> CRITICAL -> SERVICING -> OK. Levels are unchanged.
  - test_sel >= N_NEEDS: the step is ignored.
  - A rising edge while test_mode = 0 is ignored.
- Leaving test mode: normal transitions resume on the next edge from the current state, evaluated against the current level. An immediate correction transition is allowed.
- Reset mid-service or mid-test: the whole block returns to reset values immediately. No pending edge survives.
- tick coincident with a state change: the level update and the state update use the same pre-edge values.

Decomposition:
- Shared package pet_pkg holds:
  - state codes ST_OK, ST_LOW, ST_CRIT, ST_SERV;
  - mood codes;
  - the packing/index helper for level_out/state_out.
- Sub-module need_channel: one level counter, decay counter and FSM per channel. It takes a grant input and a test-advance strobe and is instantiated N_NEEDS times.
- The top level holds the arbiter, test edge detector, mood/any_critical reduction and output packing.

Test Plan:
- Reset, then 30 ticks on defaults -> all levels 4; state_out per channel = LOW on the following cycle; mood = 1.
- Continue to 60 ticks -> levels 1; all channels CRITICAL; any_critical = 1; mood = 2.
- Channel 1 in CRITICAL, btn[1] held for 6 ticks, then released:
  - SERVICING one cycle after the press; btn_enable = 4'b0010; mood = 3;
  - level rises 1 -> 7;
  - OK after release.
- btn = 4'b0110 asserted in the same cycle with both channels LOW -> channel 1 enters SERVICING; channel 2 stays LOW/CRITICAL and is ignored until release.
- test_mode = 1, test_sel = 2, three rising edges on test_step -> channel 2 goes OK -> LOW -> CRITICAL -> SERVICING; level_out unchanged; no decay during 20 ticks. test_step held high (no edge) -> no further advance.
- reset pulled low while channel 0 is SERVICING at level 5 -> all levels 7, all OK, btn_enable = 4'hF within the same cycle.
